// File: rtl/halving_subtractor_serial_pkg.sv
// Shared types and helpers for the bit-serial halving subtractor.
package halving_sub_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2
   } hs_state_t;

   // Ceiling log2, usable in constant expressions for counter sizing.
   function automatic int clog2(input int value);
      int v;
      int r;
      v = value - 1;
      r = 0;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/halving_subtractor_serial_fa_cell.sv
// Combinational 1-bit full adder; the only arithmetic element of the serial datapath.
module fa_cell (
   input  logic x,
   input  logic y,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = x ^ y ^ cin;
   assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/halving_subtractor_serial.sv
// Bit-serial signed halving subtractor: result = floor((a - b - bin) / 2),
// one bit per clock through a single full-adder cell.
module halving_subtractor_serial
   import halving_sub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             busy
);

   localparam int CNT_W = clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

   // Handshake: a transfer happens on a rising edge where valid and ready are
   // both high; out_valid stays asserted with a stable result until out_ready.
   hs_state_t        state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] a_sr_q;
   logic [WIDTH-1:0] nb_sr_q;
   logic             carry_q;
   logic [WIDTH:0]   res_sr_q;
   logic [WIDTH-1:0] result_q;
   logic             out_valid_q;

   logic             sum_bit;
   logic             carry_d;
   logic [WIDTH:0]   res_sr_d;

   fa_cell u_fa (
      .x    (a_sr_q[0]),
      .y    (nb_sr_q[0]),
      .cin  (carry_q),
      .s    (sum_bit),
      .cout (carry_d)
   );

   // New sum bits enter at the top, so after WIDTH+1 steps bit 0 holds the
   // discarded LSB and [WIDTH:1] is the halved difference.
   assign res_sr_d = {sum_bit, res_sr_q[WIDTH:1]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         a_sr_q      <= '0;
         nb_sr_q     <= '0;
         carry_q     <= 1'b0;
         res_sr_q    <= '0;
         result_q    <= '0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_sr_q   <= a;
                  nb_sr_q  <= ~b;
                  carry_q  <= ~bin;
                  cnt_q    <= '0;
                  res_sr_q <= '0;
                  state_q  <= SHIFT;
               end
            end
            SHIFT: begin
               // Sign-filling shift supplies the extension bit for step WIDTH.
               a_sr_q   <= {a_sr_q[WIDTH-1], a_sr_q[WIDTH-1:1]};
               nb_sr_q  <= {nb_sr_q[WIDTH-1], nb_sr_q[WIDTH-1:1]};
               carry_q  <= carry_d;
               res_sr_q <= res_sr_d;
               cnt_q    <= cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  result_q    <= res_sr_d[WIDTH:1];
                  out_valid_q <= 1'b1;
                  state_q     <= HOLD;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q     <= IDLE;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q == SHIFT) || (state_q == HOLD);
   assign out_valid = out_valid_q;
   assign result    = result_q;

endmodule

// File: tb/tb_halving_subtractor_serial.sv
// Bench for halving_subtractor_serial at WIDTH=8 and WIDTH=5, checked against
// an integer model of floor((a - b - bin) / 2).
module tb_halving_subtractor_serial;

   logic clk;
   logic rst;

   logic       in_valid8, in_ready8, bin8, out_valid8, out_ready8, busy8;
   logic [7:0] a8, b8, result8;
   logic       in_valid5, in_ready5, bin5, out_valid5, out_ready5, busy5;
   logic [4:0] a5, b5, result5;

   int tests_run;
   int tests_failed;

   halving_subtractor_serial #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .bin(bin8), .out_valid(out_valid8),
      .out_ready(out_ready8), .result(result8), .busy(busy8)
   );

   halving_subtractor_serial #(.WIDTH(5)) dut5 (
      .clk(clk), .rst(rst), .in_valid(in_valid5), .in_ready(in_ready5),
      .a(a5), .b(b5), .bin(bin5), .out_valid(out_valid5),
      .out_ready(out_ready5), .result(result5), .busy(busy5)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic signed [31:0] get_res(input int w);
      if (w == 8) return 32'(signed'(result8));
      return 32'(signed'(result5));
   endfunction

   function automatic logic signed [31:0] get_ov(input int w);
      return (w == 8) ? 32'(out_valid8) : 32'(out_valid5);
   endfunction

   function automatic logic signed [31:0] get_ir(input int w);
      return (w == 8) ? 32'(in_ready8) : 32'(in_ready5);
   endfunction

   function automatic logic signed [31:0] get_busy(input int w);
      return (w == 8) ? 32'(busy8) : 32'(busy5);
   endfunction

   // driver tasks
   task automatic set_in(input int w, input logic v, input int av, input int bv,
                         input logic bi);
      logic [31:0] ua;
      logic [31:0] ub;
      ua = av;
      ub = bv;
      if (w == 8) begin
         in_valid8 = v; a8 = ua[7:0]; b8 = ub[7:0]; bin8 = bi;
      end else begin
         in_valid5 = v; a5 = ua[4:0]; b5 = ub[4:0]; bin5 = bi;
      end
   endtask

   task automatic set_ordy(input int w, input logic v);
      if (w == 8) out_ready8 = v;
      else        out_ready5 = v;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: exact integer difference, floored halving.
   function automatic int ref_model(input int av, input int bv, input int bi);
      int d;
      d = av - bv - bi;
      return d >>> 1;
   endfunction

   task automatic run_op(input int w, input int av, input int bv, input int bi,
                         input int stall, input string tag);
      int n;
      int exp;
      exp = ref_model(av, bv, bi);
      n = 0;
      while (get_ir(w) != 1 && n < 50) begin
         tick();
         n++;
      end
      chk({tag, " in_ready_before"}, get_ir(w), 1);
      set_in(w, 1'b1, av, bv, bi[0]);
      tick();
      set_in(w, 1'b0, 0, 0, 1'b0);
      n = 0;
      while (get_ov(w) != 1 && n < 60) begin
         tick();
         n++;
      end
      chk({tag, " latency"}, n, w + 1);
      chk({tag, " result"}, get_res(w), exp);
      for (int i = 0; i < stall; i++) begin
         tick();
         chk({tag, " hold_valid"}, get_ov(w), 1);
         chk({tag, " hold_result"}, get_res(w), exp);
         chk({tag, " hold_in_ready"}, get_ir(w), 0);
      end
      set_ordy(w, 1'b1);
      tick();
      set_ordy(w, 1'b0);
      chk({tag, " consumed_valid"}, get_ov(w), 0);
      chk({tag, " consumed_in_ready"}, get_ir(w), 1);
      chk({tag, " result_kept"}, get_res(w), exp);
   endtask

   initial begin
      int n;
      int seen;
      tests_run    = 0;
      tests_failed = 0;
      set_in(8, 1'b0, 0, 0, 1'b0);
      set_in(5, 1'b0, 0, 0, 1'b0);
      set_ordy(8, 1'b0);
      set_ordy(5, 1'b0);

      // Reset with a coincident in_valid, which must be ignored.
      rst = 1'b1;
      tick();
      set_in(8, 1'b1, 7, 1, 1'b0);
      tick();
      rst = 1'b0;
      set_in(8, 1'b0, 0, 0, 1'b0);
      chk("reset out_valid", get_ov(8), 0);
      chk("reset result", get_res(8), 0);
      chk("reset busy", get_busy(8), 0);
      chk("reset in_ready", get_ir(8), 1);
      chk("reset5 in_ready", get_ir(5), 1);

      // Directed cases.
      run_op(8, 100, -28, 0, 2, "dir_100_m28");
      run_op(8, 5, 8, 0, 0, "dir_floor_neg");
      run_op(8, -128, 127, 1, 0, "dir_min");
      run_op(8, 127, -128, 0, 0, "dir_max");
      run_op(8, -3, 40, 1, 5, "dir_backpressure");
      run_op(5, -16, 15, 1, 1, "dir5_min");
      run_op(5, 15, -16, 0, 0, "dir5_max");

      // Reset during the 4th SHIFT cycle abandons the operation.
      set_in(8, 1'b1, 10, 0, 1'b0);
      tick();
      set_in(8, 1'b0, 0, 0, 1'b0);
      tick();
      tick();
      tick();
      chk("midrst busy_before", get_busy(8), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst in_ready", get_ir(8), 1);
      chk("midrst busy", get_busy(8), 0);
      seen = 0;
      for (int i = 0; i < 14; i++) begin
         if (out_valid8) seen = 1;
         tick();
      end
      chk("midrst no_spurious_valid", seen, 0);
      run_op(8, 3, 1, 0, 0, "post_rst");

      // Random sweeps with random ready stalls.
      for (int w = 5; w <= 8; w += 3) begin
         for (int k = 0; k < 1200; k++) begin
            int ra;
            int rb;
            int rbi;
            int st;
            ra  = int'($urandom_range(0, (1 << w) - 1));
            rb  = int'($urandom_range(0, (1 << w) - 1));
            rbi = int'($urandom_range(0, 1));
            if (ra >= (1 << (w - 1))) ra -= (1 << w);
            if (rb >= (1 << (w - 1))) rb -= (1 << w);
            st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            run_op(w, ra, rb, rbi, st, (w == 8) ? "rand8" : "rand5");
         end
      end

      n = tests_failed;
      $display("[TB] %0d tests run, %0d failed", tests_run, n);
      $finish;
   end

endmodule
